fib_stream_gen: RTL and testbench

Parametrised streaming Fibonacci-sequence generator, successor to the free-running fixed-seed generator.
- Software loads two seeds, a term count and an overflow policy, then pulses start.
- The block emits the sequence over a valid/ready stream, flags the last term and reports overflow.
- Used as a test-pattern / sequence source feeding downstream stream consumers.

---
 rtl/fib_stream_pkg.sv | 34 +++
 rtl/fib_sat_add.sv | 37 +++
 rtl/fib_stream_gen.sv | 171 +++++++++++++++++
 tb/tb_fib_stream_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_stream_pkg.sv
// -----------------------------------------------------------------------------
// fib_stream_pkg
// Shared types for the streaming Fibonacci generator.
//   ovf_mode_e : overflow policy (WRAP / SATURATE / STOP)
//   state_e    : generator FSM states
//   decode_mode: maps the raw 2-bit mode input onto ovf_mode_e; the
//                reserved code 3 behaves as WRAP.
// -----------------------------------------------------------------------------
package fib_stream_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    WRAP     = 2'd0,
    SATURATE = 2'd1,
    STOP     = 2'd2
  } ovf_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic ovf_mode_e decode_mode(input logic [MODE_W-1:0] raw);
    ovf_mode_e mode;
    case (raw)
      2'd1:    mode = SATURATE;
      2'd2:    mode = STOP;
      default: mode = WRAP;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/fib_sat_add.sv
// -----------------------------------------------------------------------------
// fib_sat_add
// Combinational adder with overflow policy applied to the sum.
// Ports:
//   i_a, i_b : operands (WIDTH bits)
//   i_mode   : overflow policy; SATURATE clamps to all-ones on carry,
//              WRAP and STOP return the modulo sum
//   o_sum    : policy-adjusted sum
//   o_carry  : raw carry-out of i_a + i_b
// -----------------------------------------------------------------------------
module fib_sat_add
  import fib_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  ovf_mode_e        i_mode,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH:0] w_raw;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b};

  // Apply the overflow policy to the raw sum.
  always_comb begin
    o_carry = w_raw[WIDTH];
    if ((i_mode == SATURATE) && w_raw[WIDTH]) begin
      o_sum = {WIDTH{1'b1}};
    end else begin
      o_sum = w_raw[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fib_stream_gen.sv
// -----------------------------------------------------------------------------
// fib_stream_gen
// Streaming Fibonacci generator: seeds, term count and overflow policy are
// captured on an accepted start; terms are then emitted over valid/ready.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : begin a sequence (ignored unless idle and count!=0)
//   seed0, seed1        : first two terms
//   count               : number of terms to emit
//   ovf_mode            : 0 WRAP, 1 SATURATE, 2 STOP, 3 treated as WRAP
//   out_data/out_index  : current term and its zero-based index
//   out_valid/out_ready : stream handshake
//   out_last            : current term is the final one
//   busy                : sequence in progress
//   overflow            : sticky overflow flag for the current/last sequence
// -----------------------------------------------------------------------------
module fib_stream_gen
  import fib_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed0,
  input  logic [DATA_WIDTH-1:0] seed1,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [1:0]            ovf_mode,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  out_index,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_done;

  logic [DATA_WIDTH-1:0] r_cur;
  logic [DATA_WIDTH-1:0] r_nxt;
  logic                  r_cur_ovf;
  logic                  r_nxt_ovf;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  r_count;
  ovf_mode_e             r_mode;
  logic                  r_overflow;
  logic                  r_last;

  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_carry;
  logic [CNT_WIDTH-1:0]  w_idx_inc;
  logic                  w_last_nxt;

  // Next term is always computed from the two held terms.
  fib_sat_add #(
    .WIDTH (DATA_WIDTH)
  ) u_add (
    .i_a     (r_cur),
    .i_b     (r_nxt),
    .i_mode  (r_mode),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_idx_inc = r_idx + CNT_ONE;
  // The term about to become current is last either by count or because the
  // term after it would overflow in STOP mode (overflowed terms never leave).
  assign w_last_nxt = (w_idx_inc == (r_count - CNT_ONE)) ||
                      ((r_mode == STOP) && w_carry);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (count != CNT_ZERO)) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_last) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Term pipeline, index, last and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur      <= {DATA_WIDTH{1'b0}};
      r_nxt      <= {DATA_WIDTH{1'b0}};
      r_cur_ovf  <= 1'b0;
      r_nxt_ovf  <= 1'b0;
      r_idx      <= CNT_ZERO;
      r_count    <= CNT_ZERO;
      r_mode     <= WRAP;
      r_overflow <= 1'b0;
      r_last     <= 1'b0;
    end else if (w_accept) begin
      r_cur      <= seed0;
      r_nxt      <= seed1;
      r_cur_ovf  <= 1'b0;
      r_nxt_ovf  <= 1'b0;
      r_idx      <= CNT_ZERO;
      r_count    <= count;
      r_mode     <= decode_mode(ovf_mode);
      r_overflow <= 1'b0;
      r_last     <= (count == CNT_ONE);
    end else if (w_xfer) begin
      // WRAP/SATURATE flag an emitted overflowed term; STOP flags the early end.
      if (r_cur_ovf || ((r_mode == STOP) && r_nxt_ovf)) begin
        r_overflow <= 1'b1;
      end
      if (w_done) begin
        // data and index hold their final values while idle
        r_last <= 1'b0;
      end else begin
        r_cur     <= r_nxt;
        r_cur_ovf <= r_nxt_ovf;
        r_nxt     <= w_sum;
        r_nxt_ovf <= w_carry;
        r_idx     <= w_idx_inc;
        r_last    <= w_last_nxt;
      end
    end
  end

  assign out_data  = r_cur;
  assign out_index = r_idx;
  assign out_valid = (r_state == RUN);
  assign busy      = (r_state == RUN);
  assign out_last  = r_last;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fib_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_fib_stream_gen
// Self-checking bench for fib_stream_gen. Two instances (32-bit and 8-bit
// data) share stimulus; a select picks which one a vector drives and watches.
// Expected terms come from a constant table and are queued per run.
// -----------------------------------------------------------------------------
module tb_fib_stream_gen;

  localparam int NV     = 12;
  localparam int BUDGET = 80;

  typedef struct {
    logic        wsel;    // 0: 32-bit instance, 1: 8-bit instance
    logic [31:0] s0;
    logic [31:0] s1;
    logic [15:0] cnt;
    logic [1:0]  mode;
    int          rdy;     // 0 always ready, 1 pattern 1,0,0,1, 2 random
    logic        poke;    // pulse start again mid-run
    int          n;       // number of expected terms
    int          ovf_at;  // index of term whose transfer sets overflow, -1 none
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [15:0] i;
    logic        l;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32;
  logic        start8;
  logic [31:0] seed0;
  logic [31:0] seed1;
  logic [15:0] count;
  logic [1:0]  ovf_mode;
  logic        out_ready;
  logic        sel;

  logic [31:0] d32_data;
  logic        d32_valid, d32_last, d32_busy, d32_ovf;
  logic [15:0] d32_index;
  logic [7:0]  d8_data;
  logic        d8_valid, d8_last, d8_busy, d8_ovf;
  logic [15:0] d8_index;

  logic [31:0] m_data;
  logic        m_valid, m_last, m_busy, m_ovf;
  logic [15:0] m_index;

  vec_t        vecs  [NV];
  logic [31:0] exp_t [NV][10];
  sb_t         sb_q  [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  fib_stream_gen #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .seed0(seed0), .seed1(seed1), .count(count), .ovf_mode(ovf_mode),
    .out_data(d32_data), .out_valid(d32_valid), .out_ready(out_ready),
    .out_last(d32_last), .out_index(d32_index), .busy(d32_busy),
    .overflow(d32_ovf)
  );

  fib_stream_gen #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .seed0(seed0[7:0]), .seed1(seed1[7:0]), .count(count), .ovf_mode(ovf_mode),
    .out_data(d8_data), .out_valid(d8_valid), .out_ready(out_ready),
    .out_last(d8_last), .out_index(d8_index), .busy(d8_busy),
    .overflow(d8_ovf)
  );

  always_comb begin
    if (sel) begin
      m_data  = {24'd0, d8_data};
      m_valid = d8_valid;
      m_last  = d8_last;
      m_busy  = d8_busy;
      m_ovf   = d8_ovf;
      m_index = d8_index;
    end else begin
      m_data  = d32_data;
      m_valid = d32_valid;
      m_last  = d32_last;
      m_busy  = d32_busy;
      m_ovf   = d32_ovf;
      m_index = d32_index;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_vectors();
    vecs[0]  = '{1'b0, 32'd1,   32'd1,   16'd8,  2'd0, 0, 1'b0, 8, -1};
    vecs[1]  = '{1'b0, 32'd1,   32'd1,   16'd8,  2'd0, 1, 1'b1, 8, -1};
    vecs[2]  = '{1'b1, 32'd89,  32'd144, 16'd5,  2'd0, 0, 1'b0, 5, 3};
    vecs[3]  = '{1'b1, 32'd89,  32'd144, 16'd5,  2'd1, 0, 1'b0, 5, 3};
    vecs[4]  = '{1'b1, 32'd89,  32'd144, 16'd10, 2'd2, 0, 1'b0, 3, 2};
    vecs[5]  = '{1'b0, 32'd7,   32'd9,   16'd1,  2'd0, 0, 1'b1, 1, -1};
    vecs[6]  = '{1'b1, 32'd200, 32'd100, 16'd2,  2'd0, 0, 1'b0, 2, -1};
    vecs[7]  = '{1'b1, 32'd89,  32'd144, 16'd5,  2'd3, 2, 1'b0, 5, 3};
    vecs[8]  = '{1'b1, 32'd250, 32'd10,  16'd4,  2'd1, 1, 1'b0, 4, 2};
    vecs[9]  = '{1'b1, 32'd1,   32'd2,   16'd4,  2'd2, 0, 1'b0, 4, -1};
    vecs[10] = '{1'b1, 32'd200, 32'd100, 16'd5,  2'd2, 1, 1'b0, 2, 1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 16'd6, 2'd2, 0, 1'b0, 2, 1};
    exp_t[0]  = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd0, 32'd0};
    exp_t[1]  = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd0, 32'd0};
    exp_t[2]  = '{32'd89, 32'd144, 32'd233, 32'd121, 32'd98, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[3]  = '{32'd89, 32'd144, 32'd233, 32'd255, 32'd255, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[4]  = '{32'd89, 32'd144, 32'd233, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[5]  = '{32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[6]  = '{32'd200, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[7]  = '{32'd89, 32'd144, 32'd233, 32'd121, 32'd98, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[8]  = '{32'd250, 32'd10, 32'd255, 32'd255, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[9]  = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[10] = '{32'd200, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_t[11] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  endtask

  // Start one vector, then stream it out against the queued expectations.
  task automatic run_vec(input int v);
    vec_t vc;
    sb_t  e;
    int   k_prev;
    bit   done;
    logic exp_o;
    vc        = vecs[v];
    sel       = vc.wsel;
    seed0     = vc.s0;
    seed1     = vc.s1;
    count     = vc.cnt;
    ovf_mode  = vc.mode;
    out_ready = 1'b0;
    sb_q.delete();
    for (int k = 0; k < vc.n; k++) begin
      sb_q.push_back('{exp_t[v][k], 16'(k), (k == vc.n - 1)});
    end
    start8  = sel;
    start32 = ~sel;
    @(posedge clk); #1;
    start8  = 1'b0;
    start32 = 1'b0;
    done    = 1'b0;
    k_prev  = -1;
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      case (vc.rdy)
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (vc.poke && cyc == 1) begin
        start8  = sel;
        start32 = ~sel;
        seed0   = 32'd99;
        count   = 16'd3;
      end else begin
        start8  = 1'b0;
        start32 = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) check($sformatf("v%0d first_valid", v), 32'(m_valid), 32'd1);
      if (k_prev >= 0) begin
        exp_o = (vc.ovf_at >= 0) && (k_prev >= vc.ovf_at);
        check($sformatf("v%0d overflow_after_t%0d", v, k_prev), 32'(m_ovf), 32'(exp_o));
        k_prev = -1;
      end
      if (m_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL v%0d extra_term: got term %0h at index %0d, expected none", v, m_data, m_index);
        end else begin
          e = sb_q[0];
          check($sformatf("v%0d data_t%0d", v, e.i), m_data, e.d);
          check($sformatf("v%0d index_t%0d", v, e.i), 32'(m_index), 32'(e.i));
          check($sformatf("v%0d last_t%0d", v, e.i), 32'(m_last), 32'(e.l));
          check($sformatf("v%0d busy_t%0d", v, e.i), 32'(m_busy), 32'd1);
          if (out_ready) begin
            void'(sb_q.pop_front());
            k_prev = int'(e.i);
            if (e.l) done = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
    end
    start8    = 1'b0;
    start32   = 1'b0;
    out_ready = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d timeout: got %0d terms left, expected 0 within %0d cycles", v, sb_q.size(), BUDGET);
    end
    @(negedge clk);
    if (k_prev >= 0) begin
      exp_o = (vc.ovf_at >= 0) && (k_prev >= vc.ovf_at);
      check($sformatf("v%0d overflow_final", v), 32'(m_ovf), 32'(exp_o));
    end
    check($sformatf("v%0d idle_valid", v), 32'(m_valid), 32'd0);
    check($sformatf("v%0d idle_busy", v), 32'(m_busy), 32'd0);
    check($sformatf("v%0d idle_data_hold", v), m_data, exp_t[v][vc.n - 1]);
    check($sformatf("v%0d idle_index_hold", v), 32'(m_index), 32'(vc.n - 1));
    check($sformatf("v%0d terms_left", v), 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Hard stop in case something wedges the main sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: got no summary, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    load_vectors();
    reset     = 1'b1;
    start32   = 1'b0;
    start8    = 1'b0;
    seed0     = 32'd0;
    seed1     = 32'd0;
    count     = 16'd0;
    ovf_mode  = 2'd0;
    out_ready = 1'b0;
    sel       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of both instances.
    @(negedge clk);
    check("rst32_valid", 32'(d32_valid), 32'd0);
    check("rst32_busy", 32'(d32_busy), 32'd0);
    check("rst32_ovf", 32'(d32_ovf), 32'd0);
    check("rst32_index", 32'(d32_index), 32'd0);
    check("rst32_data", d32_data, 32'd0);
    check("rst32_last", 32'(d32_last), 32'd0);
    check("rst8_valid", 32'(d8_valid), 32'd0);
    check("rst8_busy", 32'(d8_busy), 32'd0);
    @(posedge clk); #1;

    // start with count==0 must be ignored.
    sel     = 1'b0;
    seed0   = 32'd5;
    seed1   = 32'd6;
    count   = 16'd0;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("cnt0_valid_c%0d", c), 32'(d32_valid), 32'd0);
      check($sformatf("cnt0_busy_c%0d", c), 32'(d32_busy), 32'd0);
      @(posedge clk); #1;
    end

    for (int v = 0; v < NV; v++) begin
      run_vec(v);
    end

    // Reset in the middle of a saturating run, after overflow is already set.
    sel       = 1'b1;
    seed0     = 32'd250;
    seed1     = 32'd10;
    count     = 16'd6;
    ovf_mode  = 2'd1;
    out_ready = 1'b1;
    start8    = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    found  = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (m_valid && m_index == 16'd3) begin
        found = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("midrst_reached_t3", 32'(found), 32'd1);
    check("midrst_pre_ovf", 32'(m_ovf), 32'd1);
    check("midrst_pre_data", m_data, 32'd255);
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(m_busy), 32'd0);
    check("midrst_ovf", 32'(m_ovf), 32'd0);
    check("midrst_index", 32'(m_index), 32'd0);
    check("midrst_data", m_data, 32'd0);
    check("midrst_last", 32'(m_last), 32'd0);
    @(posedge clk); #1;

    // Clean runs after the abandoned sequence.
    run_vec(8);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
